// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_ON    = 2'd2
   } seg_state_e;

   localparam logic [3:0] DIG_A = 4'h1;
   localparam logic [3:0] DIG_B = 4'h2;
   localparam logic [3:0] DIG_C = 4'h4;
   localparam logic [3:0] DIG_D = 4'h8;

   localparam logic [3:0] SEG_BLANK_CODE = 4'hF;
   localparam logic [3:0] AN_OFF         = 4'hF;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/seg_next_digit.sv
// Picks the next enabled digit above the current one (wrapping 8 -> 1); an all-zero
// select searches from digit 0, so the same block serves the idle-to-scan start.
module seg_next_digit
   import seg_pkg::*;
(
   input  logic [3:0] select,
   input  logic [3:0] digit_mask,
   output logic [3:0] next_select,
   output logic       wrap
);

   logic [1:0] cur_idx;
   logic [1:0] idx;
   logic       found;

   always_comb begin
      cur_idx = 2'd3;
      for (int i = 0; i < 4; i++) begin
         if (select[i]) cur_idx = 2'(i);
      end
      next_select = '0;
      found       = 1'b0;
      idx         = '0;
      for (int k = 1; k <= 4; k++) begin
         idx = cur_idx + k[1:0];
         if (!found && digit_mask[idx]) begin
            found       = 1'b1;
            next_select = DIG_A << idx;
         end
      end
      // Same digit counts as a wrap: a single-digit scan completes a frame every slot.
      wrap = (next_select <= select);
   end

endmodule

// File: rtl/seg_scan_controller.sv
// Four-digit multiplexed display scanner: blank interval then on interval per digit slot.
// Optional duty control via brightness is built when SEG_PWM_EN is defined.
//
//   state    | meaning
//   ST_IDLE  | display off, waiting for run with a non-zero mask
//   ST_BLANK | new digit selected, mux and anodes off
//   ST_ON    | mux enabled, anode follows one cycle later
module seg_scan_controller
   import seg_pkg::*;
#(
   parameter int BLANK_CYCLES = 16,
   parameter int ON_CYCLES    = 4096
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       run,
   input  logic [3:0] digit_mask,
`ifdef SEG_PWM_EN
   input  logic [3:0] brightness,
`endif
   output logic [3:0] select,
   output logic       mux_enable,
   output logic [3:0] an_n,
   output logic       frame_tick
);

   localparam int CNT_W = $clog2(max_int(BLANK_CYCLES, ON_CYCLES) + 1);
   localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0] ON_LOAD    = CNT_W'(ON_CYCLES - 1);

   seg_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       select_q, select_d;
   logic             mux_en_q, mux_en_d;
   logic [3:0]       an_n_q, an_n_d;
   logic             frame_tick_q, frame_tick_d;
   logic [3:0]       nxt_sel;
   logic             nxt_wrap;
`ifdef SEG_PWM_EN
   logic [3:0]       bright_q, bright_d;
   int               pwm_limit;
`endif

   seg_next_digit u_next (
      .select      (select_q),
      .digit_mask  (digit_mask),
      .next_select (nxt_sel),
      .wrap        (nxt_wrap)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      select_d     = select_q;
      mux_en_d     = mux_en_q;
      frame_tick_d = 1'b0;
      // Anode tracks the mux one cycle late, matching the mux output register.
      an_n_d       = mux_en_q ? ~select_q : AN_OFF;
`ifdef SEG_PWM_EN
      bright_d     = bright_q;
      pwm_limit    = (int'(bright_q) + 1) * (ON_CYCLES / 16);
`endif
      if (!run || digit_mask == 4'h0) begin
         state_d  = ST_IDLE;
         cnt_d    = '0;
         select_d = '0;
         mux_en_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               select_d = nxt_sel;
               cnt_d    = BLANK_LOAD;
               state_d  = ST_BLANK;
            end
            ST_BLANK: begin
               if (cnt_q == '0) begin
                  state_d  = ST_ON;
                  cnt_d    = ON_LOAD;
                  mux_en_d = 1'b1;
`ifdef SEG_PWM_EN
                  bright_d = brightness;
`endif
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            ST_ON: begin
               if (cnt_q == '0) begin
                  select_d     = nxt_sel;
                  frame_tick_d = nxt_wrap;
                  cnt_d        = BLANK_LOAD;
                  mux_en_d     = 1'b0;
                  state_d      = ST_BLANK;
               end else begin
                  cnt_d = cnt_q - 1'b1;
`ifdef SEG_PWM_EN
                  // Next cycle's elapsed count is ON_CYCLES - cnt_q; stay lit while below the limit.
                  mux_en_d = int'(cnt_q) > (ON_CYCLES - pwm_limit);
`else
                  mux_en_d = 1'b1;
`endif
               end
            end
            default: begin
               state_d  = ST_IDLE;
               select_d = '0;
               mux_en_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         select_q     <= '0;
         mux_en_q     <= 1'b0;
         an_n_q       <= AN_OFF;
         frame_tick_q <= 1'b0;
`ifdef SEG_PWM_EN
         bright_q     <= 4'hF;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         select_q     <= select_d;
         mux_en_q     <= mux_en_d;
         an_n_q       <= an_n_d;
         frame_tick_q <= frame_tick_d;
`ifdef SEG_PWM_EN
         bright_q     <= bright_d;
`endif
      end
   end

   assign select     = select_q;
   assign mux_enable = mux_en_q;
   assign an_n       = an_n_q;
   assign frame_tick = frame_tick_q;

endmodule
